// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// instruction width and the PC increment helper.
package cpu_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with combinational head, separate occupancy counter and a
// clear input that has priority over push and pop.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clr_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, runs the req/ack handshake to
// instruction memory and queues {pc+4, instr} pairs for the IF/ID register.
module instr_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [31:0]                imem_data_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       stall_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_plus4_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic          push, pop;
  logic [CW-1:0] count, count_next;
  logic [63:0]   head;

  assign instr_valid_o = (count != '0);

  always_comb begin
    pop         = instr_valid_o && !stall_i && !redirect_i;
    push        = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
    count_next  = redirect_i ? '0 : (count + CW'(push) - CW'(pop));
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (count_next < DEPTH_C) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack_i) begin
          if (!redirect_i) fetch_pc_d = pc_inc(fetch_pc_q);
          state_d = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
        end else if (redirect_i) begin
          // The old address stays on the bus until memory answers it.
          drop_addr_d = fetch_pc_q;
          state_d     = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_i) fetch_pc_d = redirect_pc_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (redirect_i),
    .din_i   ({pc_inc(fetch_pc_q), imem_data_i}),
    .head_o  (head),
    .count_o (count)
  );

  assign count_o    = count;
  assign instr_o    = instr_valid_o ? head[31:0] : NOP_INSTR;
  assign pc_plus4_o = instr_valid_o ? head[63:32] : 32'h0;

endmodule
